// File: rtl/conv_accum.sv
// Accumulates groups of M signed products with per-step saturation and a ready/valid output register.
// Optional build macro CONV_ACCUM_RELU_EN clamps negative completed sums to zero on acc_out.
module conv_accum #(
  parameter int M = 4,
  parameter int W = 28
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] prod_in,
  input  logic                prod_valid,
  output logic                prod_ready,
  output logic signed [W-1:0] acc_out,
  output logic                acc_valid,
  input  logic                acc_ready,
  output logic                acc_sat
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(M - 1);
  localparam logic signed [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q;
  logic [CW-1:0]       tap_q, tap_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic                sat_q, sat_d;
  logic signed [W-1:0] acc_out_q, acc_out_d;
  logic                acc_sat_q;
  logic signed [W:0]   sum_w;
  logic                first_tap, last_tap, accept, ovf;

  // Clamp a W+1 bit sum back into W bits; overflow shows as disagreeing top bits.
  function automatic logic signed [W-1:0] sat_clamp(input logic signed [W:0] s);
    if (s[W] != s[W-1]) return s[W] ? NEG_MIN : POS_MAX;
    return s[W-1:0];
  endfunction

`ifdef CONV_ACCUM_RELU_EN
  function automatic logic signed [W-1:0] relu(input logic signed [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction
`endif

  always_comb begin
    first_tap  = (tap_q == '0);
    last_tap   = (tap_q == LAST_TAP);
    // Only the group-completing product can stall, and only when the result slot cannot drain.
    prod_ready = !(last_tap && (state_q == FULL) && !acc_ready);
    accept     = prod_valid && prod_ready;
    sum_w      = {acc_q[W-1], acc_q} + {prod_in[W-1], prod_in};
    ovf        = sum_w[W] ^ sum_w[W-1];
    acc_d      = first_tap ? prod_in : sat_clamp(sum_w);
    sat_d      = first_tap ? 1'b0 : (sat_q | ovf);
    tap_d      = last_tap ? '0 : tap_q + 1'b1;
`ifdef CONV_ACCUM_RELU_EN
    acc_out_d  = relu(acc_d);
`else
    acc_out_d  = acc_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      tap_q     <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      acc_out_q <= '0;
      acc_sat_q <= 1'b0;
    end else begin
      if (accept) begin
        tap_q <= tap_d;
        acc_q <= acc_d;
        sat_q <= sat_d;
      end
      // Output register: a completed group always lands; otherwise a consume drains it.
      if (accept && last_tap) begin
        state_q   <= FULL;
        acc_out_q <= acc_out_d;
        acc_sat_q <= sat_d;
      end else if (state_q == FULL && acc_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_sat   = acc_sat_q;
  assign acc_valid = (state_q == FULL);

endmodule

// File: tb/tb_conv_accum.sv
// Randomized and directed bench for conv_accum, checked cycle by cycle against a group-sum reference model.
module tb_conv_accum;

  localparam int M = 4;
  localparam int W = 28;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic                clk = 1'b0;
  logic                reset;
  logic signed [W-1:0] prod_in;
  logic                prod_valid;
  logic                prod_ready;
  logic signed [W-1:0] acc_out;
  logic                acc_valid;
  logic                acc_ready;
  logic                acc_sat;

  conv_accum #(.M(M), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .prod_ready(prod_ready),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_sat   (acc_sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: products seen in the current group, running clamped sum, result slot.
  int     m_cnt;
  longint m_run;
  bit     m_gsat;
  bit     m_valid;
  longint m_out;
  bit     m_osat;
  bit     tk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_run = 0; m_gsat = 0; m_valid = 0; m_out = 0; m_osat = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    prod_valid = 1'b1;
    prod_in = 28'sd123;
    acc_ready = 1'($urandom);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    prod_valid = 1'b0;
    model_reset();
    check("rst_acc_valid", longint'(acc_valid), 0);
    check("rst_acc_out", longint'(acc_out), 0);
    check("rst_acc_sat", longint'(acc_sat), 0);
  endtask

  // One clock: drive, check ready, advance model and DUT, check outputs.
  task automatic step(input bit v, input longint d, input bit r, output bit took);
    bit     exp_rdy;
    longint s;
    prod_valid = v;
    prod_in = d[W-1:0];
    acc_ready = r;
    #1;
    exp_rdy = !(m_cnt == M - 1 && m_valid && !r);
    check("prod_ready", longint'(prod_ready), longint'(exp_rdy));
    took = v && exp_rdy;
    @(posedge clk);
    if (m_valid && r) m_valid = 0;
    if (took) begin
      if (m_cnt == 0) begin
        m_run = d;
        m_gsat = 0;
      end else begin
        s = m_run + d;
        if (s > MAXV) begin s = MAXV; m_gsat = 1; end
        else if (s < MINV) begin s = MINV; m_gsat = 1; end
        m_run = s;
      end
      if (m_cnt == M - 1) begin
`ifdef CONV_ACCUM_RELU_EN
        m_out = (m_run < 0) ? 0 : m_run;
`else
        m_out = m_run;
`endif
        m_osat = m_gsat;
        m_valid = 1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    #1;
    check("acc_valid", longint'(acc_valid), longint'(m_valid));
    check("acc_out", longint'(acc_out), m_out);
    check("acc_sat", longint'(acc_sat), longint'(m_osat));
  endtask

  function automatic longint rand_prod();
    logic signed [W-1:0] t;
    case ($urandom_range(0, 9))
      0: return MAXV;
      1: return MINV;
      2: return longint'($urandom_range(0, 40)) - 20;
      default: begin
        t = W'($urandom);
        return longint'(t);
      end
    endcase
  endfunction

  longint p031[8] = '{10, -3, 7, 2, 10, -3, 7, 2};

  initial begin
    int i;
    int stalls;
    int n_out;
    reset = 1'b1;
    prod_valid = 1'b0;
    prod_in = '0;
    acc_ready = 1'b0;
    model_reset();
    do_reset(2);

    // Basic group sum and single-cycle valid pulse.
    step(1, 10, 1, tk); step(1, -3, 1, tk); step(1, 7, 1, tk); step(1, 2, 1, tk);
    check("r029_out", longint'(acc_out), 16);
    check("r029_valid", longint'(acc_valid), 1);
    check("r029_sat", longint'(acc_sat), 0);
    step(0, 0, 1, tk);
    check("r029_pulse_end", longint'(acc_valid), 0);

    // Positive saturation, then a clean group clears the flag.
    repeat (4) step(1, MAXV, 1, tk);
    check("r030_out", longint'(acc_out), 134217727);
    check("r030_sat", longint'(acc_sat), 1);
    repeat (4) step(1, 1, 1, tk);
    check("r030_next_out", longint'(acc_out), 4);
    check("r030_next_sat", longint'(acc_sat), 0);
    step(0, 0, 1, tk);

    // Backpressure: second group's final tap waits for the first result to drain.
    i = 0;
    stalls = 0;
    for (int k = 0; k < 20 && i < 8; k++) begin
      step(1, p031[i], stalls >= 3, tk);
      if (tk) i++;
      else stalls++;
      if (stalls > 0 && stalls < 3) check("r031_held_out", longint'(acc_out), 16);
    end
    check("r031_all_taken", i, 8);
    check("r031_stalls", stalls, 3);
    check("r031_second_out", longint'(acc_out), 16);
    check("r031_second_valid", longint'(acc_valid), 1);
    step(0, 0, 1, tk);

    // Reset mid-group discards the partial sum.
    step(1, 1, 1, tk); step(1, 2, 1, tk);
    do_reset(1);
    step(1, 1, 1, tk); step(1, 2, 1, tk); step(1, 3, 1, tk); step(1, 4, 1, tk);
    check("r032_out", longint'(acc_out), 10);

    // Negative result, with or without the rectifier.
    repeat (4) step(1, -5, 1, tk);
`ifdef CONV_ACCUM_RELU_EN
    check("r033_out", longint'(acc_out), 0);
`else
    check("r033_out", longint'(acc_out), -20);
`endif
    check("r033_sat", longint'(acc_sat), 0);

    // Back-to-back groups with a free-running consumer.
    n_out = 0;
    for (int k = 0; k < 3 * M; k++) begin
      step(1, rand_prod(), 1, tk);
      if (acc_valid) n_out++;
    end
    check("r034_results", n_out, 3);

    // Random traffic and backpressure, with an occasional reset.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      step($urandom_range(0, 9) < 7, rand_prod(), $urandom_range(0, 9) < 6, tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
